result_reader: RTL and testbench

Readback engine for the calculator datapath: after the controller has written 64-bit sum words into memory, this block reads an inclusive address range back out and streams each word as two 32-bit beats over a valid/ready handshake. It is lower half first, then upper half. It is a memory read initiator on the same single-port memory interface the controller uses, and sits between that memory and the host/test output port.

---
 rtl/calculator_pkg.sv | 18 +
 rtl/result_reader.sv | 105 ++++++++++
 tb/tb_result_reader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared constants and state encodings for the calculator datapath and its readback engine.
package calculator_pkg;

    localparam int ADDR_W        = 4;
    localparam int MEM_WORD_SIZE = 64;
    localparam int DATA_W        = MEM_WORD_SIZE / 2;

    // RD_ prefix keeps these clear of the controller's state_t literals.
    typedef enum logic [2:0] {
        RD_IDLE,
        RD_FETCH,
        RD_CAPTURE,
        RD_LO,
        RD_HI,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/result_reader.sv
// Streams an inclusive, wrapping address range of 64-bit words as lo/hi 32-bit beats; first beat 3 cycles after start, 4 cycles/word.
// Holds beat data stable under out_ready=0; no memory read is issued until the current word's hi beat is accepted.
module result_reader
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr,
    input  logic [ADDR_W-1:0]        read_end_addr,
    output logic                     read,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    rd_state_t                state_q, state_d;
    logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
    logic [MEM_WORD_SIZE-1:0] hold_q, hold_d;
    logic                     at_end;

    assign at_end = (cur_addr_q == end_addr_q);
    assign r_addr = cur_addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RD_IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        hold_d     = hold_q;
        read       = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            RD_IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    cur_addr_d = read_start_addr;
                    end_addr_d = read_end_addr;
                    state_d    = RD_FETCH;
                end
            end
            RD_FETCH: begin
                read    = 1'b1;
                state_d = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                hold_d  = r_data;
                state_d = RD_LO;
            end
            RD_LO: begin
                out_valid = 1'b1;
                out_data  = hold_q[DATA_W-1:0];
                if (out_ready) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                out_valid = 1'b1;
                out_data  = hold_q[MEM_WORD_SIZE-1:DATA_W];
                out_last  = at_end;
                if (out_ready) begin
                    if (at_end) begin
                        state_d = RD_DONE;
                    end else begin
                        // Natural overflow gives the wrap through max address to 0.
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = RD_FETCH;
                    end
                end
            end
            RD_DONE: begin
                done    = 1'b1;
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: memory model, beat/read-address scoreboards and scenario tasks.
module tb_result_reader;
    import calculator_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic                     start_i = 1'b0;
    logic [ADDR_W-1:0]        read_start_addr = '0;
    logic [ADDR_W-1:0]        read_end_addr = '0;
    logic                     read;
    logic [ADDR_W-1:0]        r_addr;
    logic [MEM_WORD_SIZE-1:0] r_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    logic [MEM_WORD_SIZE-1:0] mem [16];
    logic [DATA_W:0]          exp_q [$];
    logic [ADDR_W-1:0]        rd_q  [$];
    int                       n_chk = 0;
    int                       n_fail = 0;

    result_reader dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .read_start_addr(read_start_addr), .read_end_addr(read_end_addr),
        .read(read), .r_addr(r_addr), .r_data(r_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (read) r_data <= mem[r_addr];
    end

    task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
        logic [ADDR_W-1:0] a;
        a = s;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({1'b0, mem[a][DATA_W-1:0]});
            exp_q.push_back({(a == e), mem[a][MEM_WORD_SIZE-1:DATA_W]});
            rd_q.push_back(a);
            if (a == e) break;
            a = a + 4'd1;
        end
        @(posedge clk_i); #1;
        read_start_addr = s;
        read_end_addr   = e;
        start_i         = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int first_vld, output int done_cyc,
                               output int done_cnt, output logic busy_after);
        first_vld = -1; done_cyc = -1; done_cnt = 0; busy_after = 1'bx;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_i);
            if (out_valid && first_vld < 0) first_vld = c;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_chk++;
        if ({read, out_valid, out_last, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000", {read, out_valid, out_last, busy, done});
        end
        n_chk++;
        if ({out_data, r_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got data=%h addr=%h want 0", out_data, r_addr);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        int fv, dc, dn; logic ba;
        out_ready = 1'b1;
        do_start(4'd5, 4'd5);
        run_to_done(100, fv, dc, dn, ba);
        n_chk++;
        if (fv !== 3) begin n_fail++; $display("FAIL single_first_valid got %0d want 3", fv); end
        n_chk++;
        if (dc !== 5) begin n_fail++; $display("FAIL single_done_cycle got %0d want 5", dc); end
        n_chk++;
        if (dn !== 1) begin n_fail++; $display("FAIL single_done_pulses got %0d want 1", dn); end
        n_chk++;
        if (ba !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", ba); end
        n_chk++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_beats_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_range();
        int fv, dc, dn; logic ba;
        out_ready = 1'b1;
        do_start(4'd2, 4'd4);
        run_to_done(100, fv, dc, dn, ba);
        n_chk++;
        if (dc !== 13) begin n_fail++; $display("FAIL range_done_cycle got %0d want 13", dc); end
        n_chk++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL range_beats_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int fv, dc, dn, w; logic ba; logic [DATA_W-1:0] d0;
        out_ready = 1'b0;
        do_start(4'd7, 4'd7);
        w = 0;
        while (!out_valid && w < 20) begin @(negedge clk_i); w++; end
        d0 = out_data;
        n_chk++;
        if (d0 !== mem[7][DATA_W-1:0]) begin n_fail++; $display("FAIL bp_first_data got %h want %h", d0, mem[7][DATA_W-1:0]); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            n_chk++;
            if ({out_valid, read, out_last, out_data} !== {1'b1, 1'b0, 1'b0, d0}) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got v=%b rd=%b last=%b d=%h want v=1 rd=0 last=0 d=%h",
                         k, out_valid, read, out_last, out_data, d0);
            end
        end
        @(posedge clk_i); #1;
        out_ready = 1'b1;
        run_to_done(100, fv, dc, dn, ba);
        n_chk++;
        if (dn !== 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", dn); end
        n_chk++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_beats_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int fv, dc, dn; logic ba;
        out_ready = 1'b1;
        do_start(4'd15, 4'd1);
        run_to_done(100, fv, dc, dn, ba);
        n_chk++;
        if (dc !== 13) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 13", dc); end
        n_chk++;
        if (rd_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_left got rd=%0d beats=%0d want 0", rd_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int fv, dc, dn; logic ba;
        out_ready = 1'b1;
        do_start(4'd8, 4'd10);
        repeat (8) @(negedge clk_i);
        n_chk++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, mem[9][MEM_WORD_SIZE-1:DATA_W]}) begin
            n_fail++; $display("FAIL midrst_pre got v=%b last=%b d=%h want v=1 last=0 d=%h",
                               out_valid, out_last, out_data, mem[9][MEM_WORD_SIZE-1:DATA_W]);
        end
        #2 rst_i = 1'b1;
        #1;
        n_chk++;
        if ({read, out_valid, out_last, busy, done, out_data, r_addr} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got rd=%b v=%b last=%b busy=%b done=%b d=%h a=%h want 0",
                               read, out_valid, out_last, busy, done, out_data, r_addr);
        end
        exp_q.delete();
        rd_q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        do_start(4'd3, 4'd3);
        run_to_done(100, fv, dc, dn, ba);
        n_chk++;
        if (dc !== 5) begin n_fail++; $display("FAIL midrst_replay_done got %0d want 5", dc); end
        n_chk++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_beats_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_ignore_start();
        int dc;
        out_ready = 1'b1;
        do_start(4'd1, 4'd3);
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (done && dc < 0) dc = c;
            if (dc >= 0 && c >= dc + 3) break;
            #1;
            start_i         = (c == 2 || c == 5 || c == 9);
            read_start_addr = 4'd12;
            read_end_addr   = 4'd14;
        end
        start_i = 1'b0;
        n_chk++;
        if (dc !== 13) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want 13", dc); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after got %b want 0", busy); end
        n_chk++;
        if (rd_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL ignore_left got rd=%0d beats=%0d want 0", rd_q.size(), exp_q.size());
        end
    endtask

    initial begin
        logic [DATA_W:0] e;
        logic [ADDR_W-1:0] ea;
        for (int i = 0; i < 16; i++) begin
            mem[i] = {32'hDEAD_0000 + 32'(i), 32'h0000_BEEF + 32'(i << 16)};
        end
        mem[5] = 64'hAAAA_BBBB_1111_2222;

        fork
            forever begin
                @(negedge clk_i);
                if (!rst_i) begin
                    if (out_valid && out_ready) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL beat_unexpected got last=%b d=%h want none", out_last, out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if ({out_last, out_data} !== e) begin
                                n_fail++; $display("FAIL beat got last=%b d=%h want last=%b d=%h",
                                                   out_last, out_data, e[DATA_W], e[DATA_W-1:0]);
                            end
                        end
                    end
                    if (read) begin
                        n_chk++;
                        if (rd_q.size() == 0) begin
                            n_fail++; $display("FAIL read_unexpected got addr=%0d want none", r_addr);
                        end else begin
                            ea = rd_q.pop_front();
                            if (r_addr !== ea) begin
                                n_fail++; $display("FAIL read_addr got %0d want %0d", r_addr, ea);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_range();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_ignore_start();

        repeat (5) @(negedge clk_i);
        n_chk++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL final_idle got busy=%b beats=%0d want 0", busy, exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
